// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, round-constant lookup and the key-schedule state encoding.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        SUB,
        MIX
    } aes_state_e;

    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box, computed as the GF(2^8) inverse followed by the affine map.
// Shared between the key schedule (SubWord) and the round datapath (SubBytes).
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
    always_comb begin
        logic [7:0] pw;
        pw  = in_byte;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
    end

    assign out_byte = inv
                    ^ {inv[6:0], inv[7]}
                    ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]}
                    ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule feeding AddRoundKey, with an 11-entry key buffer.
// Define AES_KEYEXP_SBOX_REG_EN to register SubWord, splitting each round into SUB and MIX cycles.
//
// state  | meaning
// IDLE   | waiting for key_load; buffer holds the last schedule
// EXPAND | one round key generated per cycle (single-cycle build)
// SUB    | SubWord(RotWord(w3)) being registered (split build)
// MIX    | XOR chain, buffer write and stream out (split build)
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR   = AES_NR,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_load,
    input  logic [127:0]    key_in,
    output logic            key_ready,
    output logic            busy,
    output logic            rk_valid,
    output logic [IDXW-1:0] rk_idx,
    output logic [127:0]    rk_out,
    output logic            done,
    output logic            keys_valid,
    input  logic [IDXW-1:0] rd_idx,
    output logic [127:0]    rd_key
);

`ifdef AES_KEYEXP_SBOX_REG_EN
    localparam aes_state_e ROUND_START = SUB;
    localparam aes_state_e WR_STATE    = MIX;
`else
    localparam aes_state_e ROUND_START = EXPAND;
    localparam aes_state_e WR_STATE    = EXPAND;
`endif

    aes_state_e      state_q, state_d;
    logic [IDXW-1:0] rnd_q, rnd_d;
    logic            busy_q, busy_d;
    logic            rk_valid_q, rk_valid_d;
    logic [IDXW-1:0] rk_idx_q, rk_idx_d;
    logic [127:0]    rk_out_q, rk_out_d;
    logic            done_q, done_d;
    logic            keys_valid_q, keys_valid_d;
    logic [127:0]    rd_key_q, rd_key_d;
    logic [127:0]    buf_q [NR+1];
    logic [127:0]    buf_d [NR+1];

    logic [31:0]     rot_word;
    logic [31:0]     sub_word;
    logic [31:0]     sub_mix;
    logic [127:0]    next_key;

    // rk_out_q doubles as the working key: it always holds the most recent round key
    assign rot_word = {rk_out_q[23:0], rk_out_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*g +: 8]),
            .out_byte (sub_word[8*g +: 8])
        );
    end

`ifdef AES_KEYEXP_SBOX_REG_EN
    logic [31:0] sub_q, sub_d;
    assign sub_mix = sub_q;
`else
    assign sub_mix = sub_word;
`endif

    always_comb begin
        logic [31:0] w;
        w = rk_out_q[127:96] ^ sub_mix ^ {aes_rcon(rnd_q), 24'h0};
        next_key[127:96] = w;
        for (int i = 1; i < AES_NK; i++) begin
            w = w ^ rk_out_q[127-32*i -: 32];
            next_key[127-32*i -: 32] = w;
        end
    end

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        busy_d       = busy_q;
        rk_valid_d   = 1'b0;
        rk_idx_d     = rk_idx_q;
        rk_out_d     = rk_out_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        buf_d        = buf_q;
`ifdef AES_KEYEXP_SBOX_REG_EN
        sub_d        = sub_q;
`endif
        // no write bypass: a read racing a buffer write returns the old entry
        rd_key_d = (rd_idx <= IDXW'(NR)) ? buf_q[rd_idx] : 128'h0;

        if (state_q == IDLE) begin
            if (key_load) begin
                buf_d[0]     = key_in;
                rk_out_d     = key_in;
                rk_idx_d     = '0;
                rk_valid_d   = 1'b1;
                keys_valid_d = 1'b0;
                rnd_d        = IDXW'(1);
                busy_d       = 1'b1;
                state_d      = ROUND_START;
            end
`ifdef AES_KEYEXP_SBOX_REG_EN
        end else if (state_q == SUB) begin
            sub_d   = sub_word;
            state_d = MIX;
`endif
        end else if (state_q == WR_STATE) begin
            buf_d[rnd_q] = next_key;
            rk_out_d     = next_key;
            rk_idx_d     = rnd_q;
            rk_valid_d   = 1'b1;
            if (rnd_q == IDXW'(NR)) begin
                done_d       = 1'b1;
                keys_valid_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end else begin
                rnd_d   = rnd_q + IDXW'(1);
                state_d = ROUND_START;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rnd_q        <= '0;
            busy_q       <= 1'b0;
            rk_valid_q   <= 1'b0;
            rk_idx_q     <= '0;
            rk_out_q     <= '0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_key_q     <= '0;
            buf_q        <= '{default: '0};
`ifdef AES_KEYEXP_SBOX_REG_EN
            sub_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            busy_q       <= busy_d;
            rk_valid_q   <= rk_valid_d;
            rk_idx_q     <= rk_idx_d;
            rk_out_q     <= rk_out_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            rd_key_q     <= rd_key_d;
            buf_q        <= buf_d;
`ifdef AES_KEYEXP_SBOX_REG_EN
            sub_q        <= sub_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign key_ready  = !busy_q;
    assign rk_valid   = rk_valid_q;
    assign rk_idx     = rk_idx_q;
    assign rk_out     = rk_out_q;
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed FIPS-197 / zero-key vectors against a word-recursion schedule model.
// Honours AES_KEYEXP_SBOX_REG_EN for the two-cycle round timing.
module tb_aes_key_expand;

    localparam int IDXW = 4;
`ifdef AES_KEYEXP_SBOX_REG_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int LAST = 1 + 10 * STEP;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef logic [10:0][127:0] sched_t;

    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            key_load = 1'b0;
    logic [127:0]    key_in   = '0;
    logic [IDXW-1:0] rd_idx   = '0;
    logic            key_ready, busy, rk_valid, done, keys_valid;
    logic [IDXW-1:0] rk_idx;
    logic [127:0]    rk_out, rd_key;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;
    logic [127:0] cap [16];

    always #5 clk = ~clk;

    aes_key_expand #(.NR(10), .IDXW(IDXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_tbl[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic sched_t key_schedule(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        sched_t      s;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Timeline model: m_cyc counts edges since an accepted load; key k lands at m_cyc == 1 + STEP*k.
    int           m_cyc = 0;
    logic         m_busy;
    bit           m_valid, m_done, m_kv;
    int           m_idx;
    logic [127:0] m_rk, m_rd;
    sched_t       m_sched, m_buf;

    assign m_busy = (m_cyc >= 1) && (m_cyc < LAST);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   <= 0;
            m_valid <= 1'b0;
            m_done  <= 1'b0;
            m_kv    <= 1'b0;
            m_idx   <= 0;
            m_rk    <= '0;
            m_rd    <= '0;
            m_buf   <= '0;
            m_sched <= '0;
        end else begin
            m_valid <= 1'b0;
            m_done  <= 1'b0;
            m_rd    <= (rd_idx <= 4'd10) ? m_buf[rd_idx] : 128'h0;
            if (!m_busy && key_load) begin
                m_sched <= key_schedule(key_in);
                m_cyc   <= 1;
                m_valid <= 1'b1;
                m_idx   <= 0;
                m_rk    <= key_in;
                m_kv    <= 1'b0;
                m_buf[0] <= key_in;
            end else if (m_busy) begin
                m_cyc <= m_cyc + 1;
                if (m_cyc % STEP == 0) begin
                    m_valid <= 1'b1;
                    m_idx   <= m_cyc / STEP;
                    m_rk    <= m_sched[m_cyc / STEP];
                    m_buf[m_cyc / STEP] <= m_sched[m_cyc / STEP];
                    if (m_cyc / STEP == 10) begin
                        m_done <= 1'b1;
                        m_kv   <= 1'b1;
                    end
                end
            end else begin
                m_cyc <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("busy", busy, m_busy);
            check("key_ready", key_ready, !m_busy);
            check("rk_valid", rk_valid, m_valid);
            check("done", done, m_done);
            check("keys_valid", keys_valid, m_kv);
            check("rd_key", rd_key, m_rd);
            if (m_valid) begin
                check("rk_idx", rk_idx, m_idx);
                check("rk_out", rk_out, m_rk);
            end
        end
    end

    task automatic drive_load(input logic [127:0] key);
        key_in   = key;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Starts in cycle 1 after the load edge; returns in the done cycle.
    task automatic track(input int inj_cyc, input logic [127:0] inj_key, output int done_cyc);
        for (int i = 0; i < 16; i++) cap[i] = 'x;
        done_cyc = -1;
        for (int n = 1; n <= 2 * LAST && done_cyc < 0; n++) begin
            if (rk_valid) cap[rk_idx] = rk_out;
            if (done) begin
                done_cyc = n;
            end else begin
                if (n == inj_cyc) begin
                    key_in   = inj_key;
                    key_load = 1'b1;
                end
                @(negedge clk);
                key_load = 1'b0;
            end
        end
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL track_timeout: no done within %0d cycles", 2 * LAST);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_key_ready"}, key_ready, 1);
        check({tag, "_rk_valid"}, rk_valid, 0);
        check({tag, "_rk_idx"}, rk_idx, 0);
        check({tag, "_rk_out"}, rk_out, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_keys_valid"}, keys_valid, 0);
        check({tag, "_rd_key"}, rd_key, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sched_t fs, zs;
        int     dc;

        fs = key_schedule(FIPS_KEY);
        zs = key_schedule('0);
        check("model_fips_rk1", fs[1], FIPS_RK1);
        check("model_fips_rk10", fs[10], FIPS_RK10);
        check("model_zero_rk1", zs[1], ZERO_RK1);
        check("model_zero_rk10", zs[10], ZERO_RK10);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        @(negedge clk);

        // FIPS key with an ignored load attempt while busy
        drive_load(FIPS_KEY);
        track(5, '0, dc);
        check("fips_done_cycle", dc, LAST);
        check("fips_rk0", cap[0], FIPS_KEY);
        check("fips_rk1", cap[1], FIPS_RK1);
        check("fips_rk10", cap[10], FIPS_RK10);
        check("fips_keys_valid", keys_valid, 1);

        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            @(negedge clk);
            check("rd_sweep", rd_key, (i <= 10) ? fs[i] : 128'h0);
        end

        // zero key while reading entry 1 across its overwrite
        rd_idx = 4'd1;
        drive_load('0);
        track(-1, '0, dc);
        check("zero_done_cycle", dc, LAST);
        check("zero_rk1", cap[1], ZERO_RK1);
        check("zero_rk10", cap[10], ZERO_RK10);
        check("zero_keys_valid", keys_valid, 1);

        // load accepted in the done cycle
        drive_load(FIPS_KEY);
        check("b2b_rk_valid", rk_valid, 1);
        check("b2b_rk_idx", rk_idx, 0);
        check("b2b_rk_out", rk_out, FIPS_KEY);
        check("b2b_keys_valid_drop", keys_valid, 0);
        check("b2b_busy", busy, 1);
        track(-1, '0, dc);
        check("b2b_done_cycle", dc, LAST);
        rd_idx = 4'd10;
        @(negedge clk);
        check("b2b_rd10", rd_key, FIPS_RK10);

        // reset in the middle of an expansion
        drive_load('0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_done", done, 0);
        check("post_reset_keys_valid", keys_valid, 0);
        drive_load(FIPS_KEY);
        track(-1, '0, dc);
        check("reload_done_cycle", dc, LAST);
        check("reload_rk10", cap[10], FIPS_RK10);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
